logic_unit_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's fixed 16-bit split logic unit.
- Operand words are split into a high and a low field; each field takes its own runtime-selectable bitwise op.
- Two register stages with valid/ready handshake on input and output; sits between an operand source and a result consumer in the datapath.
- Power-on defaults op_hi=OR, op_lo=AND reproduce the legacy split OR/AND function exactly.

---
 rtl/logic_unit_pkg.sv | 25 ++
 rtl/logic_unit_pipe_if.sv | 52 +++++
 rtl/logic_op_slice.sv | 36 +++
 rtl/logic_unit_pipe.sv | 177 +++++++++++++++++
 tb/tb_logic_unit_pipe.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_unit_pkg.sv
// -----------------------------------------------------------------------------
// logic_unit_pkg
// Shared definitions for the pipelined split logic unit: opcode width, the
// opcode enumeration and the power-on default opcodes that reproduce the
// legacy split OR (high field) / AND (low field) behaviour.
// -----------------------------------------------------------------------------
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_PASS_A = 3'd6,
    OP_NOT_A  = 3'd7
  } op_e;

  localparam op_e DEF_OP_HI = OP_OR;
  localparam op_e DEF_OP_LO = OP_AND;

endpackage : logic_unit_pkg

// File: rtl/logic_unit_pipe_if.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe_if
// Bundles the operand-side and result-side handshakes of logic_unit_pipe.
//   master : operand source / result consumer (drives in_valid, a, b, op_hi,
//            op_lo, out_ready)
//   slave  : the logic unit itself (drives in_ready, out_valid, res, res_zero
//            and, when LOGIC_UNIT_POPCOUNT_EN is defined, res_popcnt)
// Optional feature macro: LOGIC_UNIT_POPCOUNT_EN adds res_popcnt.
// -----------------------------------------------------------------------------
interface logic_unit_pipe_if
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OP_W-1:0]  op_hi;
  logic [OP_W-1:0]  op_lo;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             res_zero;
`ifdef LOGIC_UNIT_POPCOUNT_EN
  logic [CNT_W-1:0] res_popcnt;
`endif

`ifdef LOGIC_UNIT_POPCOUNT_EN
  modport master (
    output in_valid, a, b, op_hi, op_lo, out_ready,
    input  in_ready, out_valid, res, res_zero, res_popcnt
  );
  modport slave (
    input  in_valid, a, b, op_hi, op_lo, out_ready,
    output in_ready, out_valid, res, res_zero, res_popcnt
  );
`else
  modport master (
    output in_valid, a, b, op_hi, op_lo, out_ready,
    input  in_ready, out_valid, res, res_zero
  );
  modport slave (
    input  in_valid, a, b, op_hi, op_lo, out_ready,
    output in_ready, out_valid, res, res_zero
  );
`endif

endinterface : logic_unit_pipe_if

// File: rtl/logic_op_slice.sv
// -----------------------------------------------------------------------------
// logic_op_slice
// Purely combinational W-bit bitwise operator.
//   a_i  [W-1:0] operand A field
//   b_i  [W-1:0] operand B field
//   op_i op_e    operation select
//   y_o  [W-1:0] result field
// -----------------------------------------------------------------------------
module logic_op_slice
  import logic_unit_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  op_e          op_i,
  output logic [W-1:0] y_o
);

  // Bitwise operator select; every op is per-bit so no carry ever leaves the field.
  always_comb begin
    y_o = {W{1'b0}};
    case (op_i)
      OP_AND:    y_o = a_i & b_i;
      OP_OR:     y_o = a_i | b_i;
      OP_XOR:    y_o = a_i ^ b_i;
      OP_NAND:   y_o = ~(a_i & b_i);
      OP_NOR:    y_o = ~(a_i | b_i);
      OP_XNOR:   y_o = ~(a_i ^ b_i);
      OP_PASS_A: y_o = a_i;
      OP_NOT_A:  y_o = ~a_i;
      default:   y_o = {W{1'b0}};
    endcase
  end

endmodule : logic_op_slice

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
// Two-stage pipelined split logic unit. The operand word is split into a high
// field res[WIDTH-1:LO_W] and a low field res[LO_W-1:0]; each field applies its
// own opcode, sampled together with the operands on an accepted beat.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (clears all in-flight beats)
//   bus  : logic_unit_pipe_if.slave
//          in_valid/in_ready, a, b, op_hi, op_lo  -> operand beat
//          out_valid/out_ready, res, res_zero     -> result beat
//          res_popcnt (only with LOGIC_UNIT_POPCOUNT_EN) -> number of 1s in res
// Stage 1 captures the beat, stage 2 computes and registers the result, so a
// result appears two cycles after acceptance and one beat per cycle flows.
// Optional feature macro: LOGIC_UNIT_POPCOUNT_EN.
// -----------------------------------------------------------------------------
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LO_W  = WIDTH / 2
) (
  input logic               clk,
  input logic               rst,
  logic_unit_pipe_if.slave  bus
);

  localparam int HI_W  = WIDTH - LO_W;
  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef LOGIC_UNIT_POPCOUNT_EN
  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = {CNT_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction
`endif

  // Handshake control
  logic adv1_s;
  logic adv2_s;
  logic accept_s;

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  op_e              op_hi_q, op_hi_d;
  op_e              op_lo_q, op_lo_d;

  // Stage 2 registers
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             res_zero_q, res_zero_d;
`ifdef LOGIC_UNIT_POPCOUNT_EN
  logic [CNT_W-1:0] popcnt_q, popcnt_d;
`endif

  // Combinational result of the stage-1 contents
  logic [HI_W-1:0]  hi_y_s;
  logic [LO_W-1:0]  lo_y_s;
  logic [WIDTH-1:0] res_s;

  // Ready chain depends only on registered valids and out_ready, never on in_valid.
  assign adv2_s   = !s2_valid_q || bus.out_ready;
  assign adv1_s   = !s1_valid_q || adv2_s;
  assign accept_s = bus.in_valid && adv1_s;

  logic_op_slice #(.W(HI_W)) u_hi_slice (
    .a_i  (a_q[WIDTH-1:LO_W]),
    .b_i  (b_q[WIDTH-1:LO_W]),
    .op_i (op_hi_q),
    .y_o  (hi_y_s)
  );

  logic_op_slice #(.W(LO_W)) u_lo_slice (
    .a_i  (a_q[LO_W-1:0]),
    .b_i  (b_q[LO_W-1:0]),
    .op_i (op_lo_q),
    .y_o  (lo_y_s)
  );

  assign res_s = {hi_y_s, lo_y_s};

  // Stage 1 next state: refill when stage 1 advances, load payload only on a real accept.
  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    op_hi_d    = op_hi_q;
    op_lo_d    = op_lo_q;
    if (adv1_s) begin
      s1_valid_d = bus.in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (accept_s) begin
      a_d     = bus.a;
      b_d     = bus.b;
      op_hi_d = op_e'(bus.op_hi);
      op_lo_d = op_e'(bus.op_lo);
    end else begin
      a_d     = a_q;
      b_d     = b_q;
      op_hi_d = op_hi_q;
      op_lo_d = op_lo_q;
    end
  end

  // Stage 2 next state: result fields only change when a valid stage-1 beat moves in.
  always_comb begin
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    res_zero_d = res_zero_q;
`ifdef LOGIC_UNIT_POPCOUNT_EN
    popcnt_d   = popcnt_q;
`endif
    if (adv2_s) begin
      s2_valid_d = s1_valid_q;
    end else begin
      s2_valid_d = s2_valid_q;
    end
    if (adv2_s && s1_valid_q) begin
      res_d      = res_s;
      res_zero_d = (res_s == {WIDTH{1'b0}});
`ifdef LOGIC_UNIT_POPCOUNT_EN
      popcnt_d   = popcount(res_s);
`endif
    end else begin
      res_d      = res_q;
      res_zero_d = res_zero_q;
`ifdef LOGIC_UNIT_POPCOUNT_EN
      popcnt_d   = popcnt_q;
`endif
    end
  end

  // Pipeline state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      a_q        <= {WIDTH{1'b0}};
      b_q        <= {WIDTH{1'b0}};
      op_hi_q    <= DEF_OP_HI;
      op_lo_q    <= DEF_OP_LO;
      s2_valid_q <= 1'b0;
      res_q      <= {WIDTH{1'b0}};
      res_zero_q <= 1'b1;
`ifdef LOGIC_UNIT_POPCOUNT_EN
      popcnt_q   <= {CNT_W{1'b0}};
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_hi_q    <= op_hi_d;
      op_lo_q    <= op_lo_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      res_zero_q <= res_zero_d;
`ifdef LOGIC_UNIT_POPCOUNT_EN
      popcnt_q   <= popcnt_d;
`endif
    end
  end

  assign bus.in_ready   = adv1_s;
  assign bus.out_valid  = s2_valid_q;
  assign bus.res        = res_q;
  assign bus.res_zero   = res_zero_q;
`ifdef LOGIC_UNIT_POPCOUNT_EN
  assign bus.res_popcnt = popcnt_q;
`endif

endmodule : logic_unit_pipe

// File: tb/tb_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_pipe
// Scoreboard bench: stimulus pushes expected results into a queue when a beat
// is accepted; monitor processes pop and compare whenever a result is popped.
// A second instance covers WIDTH=32, LO_W=8.
// -----------------------------------------------------------------------------
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  typedef struct {
    logic [15:0] res;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   pops16 = 0;
  int   pops32 = 0;
  exp_t        sb[$];
  logic [31:0] sb32[$];

  logic_unit_pipe_if #(.WIDTH(16)) bus16 ();
  logic_unit_pipe_if #(.WIDTH(32)) bus32 ();

  logic_unit_pipe #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  logic_unit_pipe #(.WIDTH(32), .LO_W(8)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] bw(input logic [15:0] x, input logic [15:0] y, input int op);
    case (op)
      0: return x & y;
      1: return x | y;
      2: return x ^ y;
      3: return ~(x & y);
      4: return ~(x | y);
      5: return ~(x ^ y);
      6: return x;
      default: return ~x;
    endcase
  endfunction

  // Drive one beat, hold it until accepted (bounded), push the expectation on accept.
  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic [2:0] oh,
                      input logic [2:0] ol, input logic [15:0] exp, input bit lat);
    int  n;
    bit  done;
    exp_t e;
    n = 0;
    done = 1'b0;
    bus16.in_valid = 1'b1;
    bus16.a = av;
    bus16.b = bv;
    bus16.op_hi = oh;
    bus16.op_lo = ol;
    while (!done) begin
      @(negedge clk);
      if (bus16.in_ready) begin
        e.res = exp;
        e.acc_cyc = cyc;
        e.chk_lat = lat;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 50) begin
        checks++;
        failures++;
        $display("FAIL send_timeout got=in_ready_low expected=accept");
        done = 1'b1;
      end
    end
    bus16.in_valid = 1'b0;
  endtask

  // 16-bit result monitor.
  initial begin
    exp_t e;
    logic [15:0] r;
    forever begin
      @(negedge clk);
      if (!rst && bus16.out_valid && bus16.out_ready) begin
        pops16++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result got=%0h expected=none", bus16.res);
        end else begin
          e = sb.pop_front();
          r = e.res;
          chk("res", 64'(bus16.res), 64'(r));
          chk("res_zero", 64'(bus16.res_zero), 64'(r == 16'h0000));
`ifdef LOGIC_UNIT_POPCOUNT_EN
          chk("res_popcnt", 64'(bus16.res_popcnt), 64'($countones(r)));
`endif
          if (e.chk_lat) chk("latency", 64'(cyc - e.acc_cyc), 64'd2);
        end
      end
    end
  end

  // 32-bit result monitor.
  initial begin
    logic [31:0] r;
    forever begin
      @(negedge clk);
      if (!rst && bus32.out_valid && bus32.out_ready) begin
        pops32++;
        if (sb32.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result32 got=%0h expected=none", bus32.res);
        end else begin
          r = sb32.pop_front();
          chk("res32", 64'(bus32.res), 64'(r));
          chk("res_zero32", 64'(bus32.res_zero), 64'(r == 32'h0));
`ifdef LOGIC_UNIT_POPCOUNT_EN
          // 32'h12345687 contains 13 ones.
          chk("res_popcnt32", 64'(bus32.res_popcnt), 64'd13);
`endif
        end
      end
    end
  end

  initial begin
    logic [15:0] mh;
    logic [15:0] ml;
    bit stale;
    rst = 1'b1;
    bus16.in_valid = 1'b0;
    bus16.a = 16'h0000;
    bus16.b = 16'h0000;
    bus16.op_hi = 3'd0;
    bus16.op_lo = 3'd0;
    bus16.out_ready = 1'b1;
    bus32.in_valid = 1'b0;
    bus32.a = 32'h0;
    bus32.b = 32'h0;
    bus32.op_hi = 3'd0;
    bus32.op_lo = 3'd0;
    bus32.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(bus16.out_valid), 64'd0);
    chk("rst_res", 64'(bus16.res), 64'd0);
    chk("rst_res_zero", 64'(bus16.res_zero), 64'd1);
    chk("rst_in_ready", 64'(bus16.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Legacy split OR/AND with latency check
    send(16'hF0F0, 16'h0FF0, DEF_OP_HI, DEF_OP_LO, 16'hFFF0, 1'b1);
    send(16'hA5C3, 16'h0FF0, 3'd2, 3'd2, 16'hAA33, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // Full opcode sweep streamed back to back
    for (int oh = 0; oh < 8; oh++) begin
      for (int ol = 0; ol < 8; ol++) begin
        mh = bw(16'hA5C3, 16'h0FF0, oh);
        ml = bw(16'hA5C3, 16'h0FF0, ol);
        send(16'hA5C3, 16'h0FF0, 3'(oh), 3'(ol), {mh[15:8], ml[7:0]}, 1'b1);
      end
    end
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: two beats fill the pipe, then the source stalls
    bus16.out_ready = 1'b0;
    send(16'h1234, 16'h00FF, 3'd0, 3'd0, 16'h0034, 1'b0);
    send(16'hFFFF, 16'h0F0F, 3'd2, 3'd2, 16'hF0F0, 1'b0);
    fork
      begin
        send(16'hAAAA, 16'h5555, 3'd3, 3'd4, 16'hFF00, 1'b0);
        send(16'h1234, 16'hFFFF, 3'd6, 3'd7, 16'h12CB, 1'b0);
        send(16'h0000, 16'h0000, 3'd5, 3'd1, 16'hFF00, 1'b0);
      end
      begin
        @(negedge clk);
        chk("bp_in_ready", 64'(bus16.in_ready), 64'd0);
        chk("bp_out_valid", 64'(bus16.out_valid), 64'd1);
        chk("bp_res", 64'(bus16.res), 64'h0034);
        repeat (3) @(negedge clk);
        chk("bp_res_hold", 64'(bus16.res), 64'h0034);
        chk("bp_in_ready_hold", 64'(bus16.in_ready), 64'd0);
        @(posedge clk);
        #1 bus16.out_ready = 1'b1;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    chk("bp_drained", 64'(sb.size()), 64'd0);

    // Zero flag
    send(16'h00FF, 16'hFF00, 3'd0, 3'd0, 16'h0000, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("pops16", 64'(pops16), 64'd72);

    // Reset with both stages full
    bus16.out_ready = 1'b0;
    send(16'h1111, 16'h2222, 3'd1, 3'd1, 16'h3333, 1'b0);
    send(16'h4444, 16'h8888, 3'd1, 3'd1, 16'hCCCC, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(bus16.out_valid), 64'd0);
    chk("mid_rst_res", 64'(bus16.res), 64'd0);
    chk("mid_rst_res_zero", 64'(bus16.res_zero), 64'd1);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    bus16.out_ready = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus16.out_valid) stale = 1'b1;
    end
    chk("no_stale_beat", 64'(stale), 64'd0);

    // WIDTH=32, LO_W=8: PASS_A high, NOT_A low
    @(posedge clk);
    #1;
    bus32.in_valid = 1'b1;
    bus32.a = 32'h12345678;
    bus32.b = 32'h0;
    bus32.op_hi = 3'd6;
    bus32.op_lo = 3'd7;
    @(negedge clk);
    chk("in_ready32", 64'(bus32.in_ready), 64'd1);
    if (bus32.in_ready) sb32.push_back(32'h12345687);
    @(posedge clk);
    #1 bus32.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pops32", 64'(pops32), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_logic_unit_pipe
